exp_rebias_unit: RTL and testbench

EXP_REBIAS_UNIT -- requirements
Module: exp_rebias_unit

---
 rtl/exp_rebias_unit_pkg.sv | 20 ++
 rtl/exp_range_check.sv | 40 ++++
 rtl/exp_rebias_unit.sv | 99 +++++++++
 tb/tb_exp_rebias_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/exp_rebias_unit_pkg.sv
// ============================================================================
// Module : exp_rebias_unit_pkg
// Brief  : Shared FPU exponent defaults, saturation limit and FSM encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package exp_rebias_unit_pkg;
    localparam int W_DEFAULT    = 9;
    localparam int EW_DEFAULT   = 8;
    localparam int BIAS_DEFAULT = 127;
    localparam int EXP_MAX      = (1 << EW_DEFAULT) - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_ADJ  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
endpackage

`default_nettype wire

// File: rtl/exp_range_check.sv
// ============================================================================
// Module : exp_range_check
// Brief  : Saturates a signed rebiased exponent into [0, 2^EW-1] with flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module exp_range_check
    import exp_rebias_unit_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int EW = EW_DEFAULT
) (
    input  logic signed [W+1:0] value,
    output logic [EW-1:0]       exp_out,
    output logic                overflow,
    output logic                underflow
);
    localparam int MAX_L = (1 << EW) - 1;

    logic signed [31:0] w_ext;

    assign w_ext = 32'(value);

    // The all-ones code is reserved for Inf, so reaching it already saturates.
    always_comb begin
        overflow  = 1'b0;
        underflow = 1'b0;
        exp_out   = w_ext[EW-1:0];
        if (w_ext >= MAX_L) begin
            overflow = 1'b1;
            exp_out  = EW'(MAX_L);
        end else if (w_ext <= 0) begin
            underflow = 1'b1;
            exp_out   = '0;
        end
    end
endmodule

`default_nettype wire

// File: rtl/exp_rebias_unit.sv
// ============================================================================
// Module : exp_rebias_unit
// Brief  : Multi-cycle exponent rebias/normalise/saturate with ready/ack.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module exp_rebias_unit
    import exp_rebias_unit_pkg::*;
#(
    parameter int W    = W_DEFAULT,
    parameter int EW   = EW_DEFAULT,
    parameter int BIAS = BIAS_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  exp_in,
    input  logic          norm_inc,
    input  logic          ack,
    output logic          busy,
    output logic          ready,
    output logic [EW-1:0] exp_out,
    output logic          overflow,
    output logic          underflow
);
    logic [1:0]          r_state;
    logic signed [W-1:0] r_exp;
    logic                r_inc;
    logic signed [W+1:0] r_sum;
    logic [EW-1:0]       r_exp_out;
    logic                r_ovf;
    logic                r_unf;

    logic signed [W+1:0] w_sum;
    logic signed [W+1:0] w_adj;
    logic [EW-1:0]       w_exp_out;
    logic                w_ovf;
    logic                w_unf;

    assign w_sum = {{2{r_exp[W-1]}}, r_exp} + $signed((W+2)'(BIAS));
    assign w_adj = r_sum + $signed({{(W+1){1'b0}}, r_inc});

    exp_range_check #(
        .W  (W),
        .EW (EW)
    ) u_range (
        .value     (w_adj),
        .exp_out   (w_exp_out),
        .overflow  (w_ovf),
        .underflow (w_unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_exp     <= '0;
            r_inc     <= 1'b0;
            r_sum     <= '0;
            r_exp_out <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_exp   <= $signed(exp_in);
                        r_inc   <= norm_inc;
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_sum   <= w_sum;
                    r_state <= ST_ADJ;
                end
                ST_ADJ: begin
                    r_exp_out <= w_exp_out;
                    r_ovf     <= w_ovf;
                    r_unf     <= w_unf;
                    r_state   <= ST_DONE;
                end
                default: begin
                    // Result is held until consumed; a load here is dropped.
                    if (ack) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign ready     = (r_state == ST_DONE);
    assign exp_out   = r_exp_out;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
endmodule

`default_nettype wire

// File: tb/tb_exp_rebias_unit.sv
// ============================================================================
// Module : tb_exp_rebias_unit
// Brief  : Directed vector table plus handshake/reset sequences.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_exp_rebias_unit;
    logic       clk;
    logic       rst;
    logic       load;
    logic [8:0] exp_in;
    logic       norm_inc;
    logic       ack;
    logic       busy;
    logic       ready;
    logic [7:0] exp_out;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    exp_rebias_unit dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .exp_in    (exp_in),
        .norm_inc  (norm_inc),
        .ack       (ack),
        .busy      (busy),
        .ready     (ready),
        .exp_out   (exp_out),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] e;
        logic       inc;
        logic [7:0] eo;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic start_op(input logic [8:0] e, input logic inc);
        @(negedge clk);
        load     = 1'b1;
        exp_in   = e;
        norm_inc = inc;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Counts edges from the capturing edge until ready, bounded.
    task automatic wait_ready(output int cyc);
        cyc = 1;
        while (!ready && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        int cyc;

        vecs[0]  = '{9'd3,   1'b0, 8'd130, 1'b0, 1'b0};
        vecs[1]  = '{9'd128, 1'b0, 8'd255, 1'b1, 1'b0};
        vecs[2]  = '{9'd127, 1'b1, 8'd255, 1'b1, 1'b0};
        vecs[3]  = '{9'h181, 1'b0, 8'd0,   1'b0, 1'b1};
        vecs[4]  = '{9'h182, 1'b0, 8'd1,   1'b0, 1'b0};
        vecs[5]  = '{9'h181, 1'b1, 8'd1,   1'b0, 1'b0};
        vecs[6]  = '{9'd0,   1'b0, 8'd127, 1'b0, 1'b0};
        vecs[7]  = '{9'd127, 1'b0, 8'd254, 1'b0, 1'b0};
        vecs[8]  = '{9'h180, 1'b0, 8'd0,   1'b0, 1'b1};
        vecs[9]  = '{9'h0FF, 1'b1, 8'd255, 1'b1, 1'b0};
        vecs[10] = '{9'h100, 1'b0, 8'd0,   1'b0, 1'b1};
        vecs[11] = '{9'd126, 1'b1, 8'd254, 1'b0, 1'b0};

        rst = 1'b1; load = 1'b0; exp_in = '0; norm_inc = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy",  32'(busy),      32'd0);
        chk("reset_ready", 32'(ready),     32'd0);
        chk("reset_exp",   32'(exp_out),   32'd0);
        chk("reset_ovf",   32'(overflow),  32'd0);
        chk("reset_unf",   32'(underflow), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].e, vecs[i].inc);
            chk("busy_after_load", 32'(busy), 32'd1);
            wait_ready(cyc);
            chk("latency",   32'(cyc),       32'd3);
            chk("vec_exp",   32'(exp_out),   32'(vecs[i].eo));
            chk("vec_ovf",   32'(overflow),  32'(vecs[i].ov));
            chk("vec_unf",   32'(underflow), 32'(vecs[i].un));
            do_ack();
            chk("ack_idle",  32'(busy),      32'd0);
            chk("hold_idle", 32'(exp_out),   32'(vecs[i].eo));
        end

        // ack in IDLE is a no-op
        do_ack();
        chk("idle_ack_busy", 32'(busy),    32'd0);
        chk("idle_ack_exp",  32'(exp_out), 32'd126 + 32'd128);

        // load held through ADD/ADJ/DONE, then load+ack together in DONE
        start_op(9'd3, 1'b0);
        load = 1'b1; exp_in = 9'd50;
        @(negedge clk);
        @(negedge clk);
        chk("ign_ready", 32'(ready),   32'd1);
        chk("ign_exp",   32'(exp_out), 32'd130);
        ack = 1'b1;
        @(negedge clk);
        load = 1'b0; ack = 1'b0;
        chk("ign_idle", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("ign_no_second_busy",  32'(busy),    32'd0);
        chk("ign_no_second_ready", 32'(ready),   32'd0);
        chk("ign_exp_kept",        32'(exp_out), 32'd130);

        // ack during ADD/ADJ must not disturb the operation
        start_op(9'd10, 1'b1);
        ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ack = 1'b0;
        chk("early_ack_ready", 32'(ready),   32'd1);
        chk("early_ack_exp",   32'(exp_out), 32'd138);
        @(negedge clk);
        chk("early_ack_hold",  32'(ready),   32'd1);
        do_ack();

        // reset in ADJ
        start_op(9'd100, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_adj_busy",  32'(busy),      32'd0);
        chk("rst_adj_ready", 32'(ready),     32'd0);
        chk("rst_adj_exp",   32'(exp_out),   32'd0);
        chk("rst_adj_flags", 32'({overflow, underflow}), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_adj_stay_idle", 32'(busy), 32'd0);
        start_op(9'd0, 1'b0);
        wait_ready(cyc);
        chk("post_rst_lat", 32'(cyc),     32'd3);
        chk("post_rst_exp", 32'(exp_out), 32'd127);
        do_ack();

        // result held 10 cycles without ack
        start_op(9'd128, 1'b0);
        wait_ready(cyc);
        for (int k = 0; k < 10; k++) begin
            chk("hold_ready", 32'(ready),   32'd1);
            chk("hold_exp",   32'(exp_out), 32'd255);
            chk("hold_ovf",   32'(overflow), 32'd1);
            @(negedge clk);
        end
        do_ack();
        chk("final_busy",  32'(busy),  32'd0);
        chk("final_ready", 32'(ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
